// File: rtl/seq_divider_32.sv
// rtl/seq_divider_32.sv - multi-cycle restoring divider for DIV/DIVU with signed correction
module seq_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Sign,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  state_t           state_nxt;

  // p carries one spare top bit so the trial subtraction sees the full shifted value
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dv_mag;
  logic [CW-1:0]    cnt;
  logic             qsign;
  logic             rsign;
  logic             dz;

  logic [WIDTH-1:0] dd_mag_in;
  logic [WIDTH-1:0] dv_mag_in;
  logic [WIDTH+1:0] trial;
  logic             last_iter;

  // operand magnitudes, trial subtraction and loop-end detection
  always_comb begin
    dd_mag_in = (Sign && Dividend[WIDTH-1]) ? -Dividend : Dividend;
    dv_mag_in = (Sign && Divisor[WIDTH-1])  ? -Divisor  : Divisor;
    trial     = {p, q[WIDTH-1]} - {2'b00, dv_mag};
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic: IDLE -> RUN on Start, RUN for WIDTH iterations, one FIX cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    Busy = (state != IDLE);
  end

  // datapath: operand capture, shift-subtract loop, sign correction and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p         <= '0;
      q         <= '0;
      dv_mag    <= '0;
      cnt       <= '0;
      qsign     <= 1'b0;
      rsign     <= 1'b0;
      dz        <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            p      <= '0;
            q      <= dd_mag_in;
            dv_mag <= dv_mag_in;
            cnt    <= '0;
            qsign  <= Sign & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
            rsign  <= Sign & Dividend[WIDTH-1];
            dz     <= (Divisor == '0);
          end
        end
        RUN: begin
          if (!trial[WIDTH+1]) begin
            p <= trial[WIDTH:0];
            q <= {q[WIDTH-2:0], 1'b1};
          end else begin
            p <= {p[WIDTH-1:0], q[WIDTH-1]};
            q <= {q[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          // a zero divisor leaves p holding |Dividend|, so the rsign fix-up restores the raw dividend
          Quotient  <= dz ? '1 : (qsign ? -q : q);
          Remainder <= rsign ? -p[WIDTH-1:0] : p[WIDTH-1:0];
          DivByZero <= dz;
          Done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_32.sv
// tb/tb_seq_divider_32.sv - randomized scoreboard bench for seq_divider_32
module tb_seq_divider_32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start;
  logic         Sign;
  logic [W-1:0] Dividend;
  logic [W-1:0] Divisor;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         DivByZero;

  seq_divider_32 #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Sign(Sign),
    .Dividend(Dividend), .Divisor(Divisor), .Busy(Busy), .Done(Done),
    .Quotient(Quotient), .Remainder(Remainder), .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           t0;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] held_q = '0;
  logic [W-1:0] held_r = '0;
  logic         prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: plain integer division rules of DIV/DIVU including the two special cases
  function automatic exp_t model(input bit s, input logic [W-1:0] dd, input logic [W-1:0] dv);
    exp_t e;
    e.dz = 1'b0;
    e.t0 = 0;
    if (dv == 0) begin
      e.q = '1; e.r = dd; e.dz = 1'b1;
    end else if (!s) begin
      e.q = dd / dv; e.r = dd % dv;
    end else if (dd == 32'h8000_0000 && dv == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = '0;
    end else begin
      e.q = $signed(dd) / $signed(dv);
      e.r = $signed(dd) % $signed(dv);
    end
    return e;
  endfunction

  // monitor: result stability while busy, then pop-and-compare on every Done
  always @(negedge clk) begin
    if (!reset) begin
      if (Busy) begin
        check("q_stable", Quotient, held_q);
        check("r_stable", Remainder, held_r);
      end
      if (Done) begin
        check("done_pulse", {31'd0, prev_done}, 0);
        if (sb.size() == 0) begin
          check("unexpected_done", {31'd0, Done}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", Quotient, e.q);
          check("remainder", Remainder, e.r);
          check("divbyzero", {31'd0, DivByZero}, {31'd0, e.dz});
          // Start seen at edge t0+1, Done observed after edge t0+1+W+1
          check("latency", cyc - e.t0, W + 2);
          held_q = e.q;
          held_r = e.r;
        end
      end
    end
    prev_done = Done;
  end

  task automatic issue(input bit s, input logic [W-1:0] dd, input logic [W-1:0] dv);
    exp_t e;
    e = model(s, dd, dv);
    e.t0 = cyc;
    sb.push_back(e);
    Start = 1'b1; Sign = s; Dividend = dd; Divisor = dv;
    @(negedge clk);
    Start = 1'b0;
    check("busy_after_start", {31'd0, Busy}, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", {31'd0, Busy}, 0);
  endtask

  task automatic do_op(input bit s, input logic [W-1:0] dd, input logic [W-1:0] dv);
    wait_idle();
    issue(s, dd, dv);
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; Sign = 1'b0; Dividend = '0; Divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, Busy}, 0);
    check("rst_done", {31'd0, Done}, 0);
    check("rst_q", Quotient, 0);
    check("rst_r", Remainder, 0);
    check("rst_dz", {31'd0, DivByZero}, 0);
    reset = 1'b0;
    @(negedge clk);

    do_op(1'b0, 32'd100, 32'd7);
    do_op(1'b1, -32'sd7, 32'd2);
    do_op(1'b1, 32'd7, -32'sd2);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1'b1, 32'd5, 32'd0);
    do_op(1'b1, -32'sd5, 32'd0);
    do_op(1'b0, 32'h8000_0000, 32'd0);
    do_op(1'b0, 32'd3, 32'hFFFF_FFFF);

    // Start while busy must be ignored
    do_op(1'b0, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    Start = 1'b1; Sign = 1'b1; Dividend = 32'd12345; Divisor = 32'd11;
    @(negedge clk);
    Start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    check("no_rerun", {31'd0, Busy}, 0);

    // back-to-back Start on the Done cycle
    do_op(1'b0, 32'd1000, 32'd3);
    begin
      int n = 0;
      while (!Done && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("b2b_done_seen", {31'd0, Done}, 1);
    end
    issue(1'b1, -32'sd100, 32'd9);

    // reset in the middle of RUN
    wait_idle();
    issue(1'b1, 32'd987654, -32'sd321);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, Busy}, 0);
    check("midrst_done", {31'd0, Done}, 0);
    check("midrst_q", Quotient, 0);
    check("midrst_r", Remainder, 0);
    check("midrst_dz", {31'd0, DivByZero}, 0);
    sb.delete();
    held_q = '0;
    held_r = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    do_op(1'b0, 32'd77, 32'd5);

    // randomized mix with occasional corner operands
    repeat (150) begin
      bit           s;
      logic [W-1:0] dd;
      logic [W-1:0] dv;
      int           mode;
      s    = 1'($urandom_range(0, 1));
      dd   = $urandom;
      dv   = $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0: dv = '0;
        1: dv = $urandom_range(1, 15);
        2: begin dd = 32'h8000_0000; dv = 32'hFFFF_FFFF; end
        3: dv = dv >> $urandom_range(0, 31);
        default: ;
      endcase
      do_op(s, dd, dv);
    end

    begin
      int n = 0;
      while (sb.size() > 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("drain", sb.size(), 0);
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
